// File: rtl/bitsa_tx_pkg.sv
// rtl/bitsa_tx_pkg.sv - shared types for the bitsa serial transmitter
// Holds the FSM state encoding and the default frame tag type.
// Optional feature macro: BITSA_SERIAL_TX_PARITY_EN (adds the PARITY state).
package bitsa_tx_pkg;

    typedef logic [2:0] bitsa_tag_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_TAG,
        ST_DATA,
`ifdef BITSA_SERIAL_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_GAP
    } bitsa_state_e;

endpackage

// File: rtl/bitsa_serial_tx.sv
// rtl/bitsa_serial_tx.sv - tagged word serializer driving a shared one-wire bus
// Sends: start bit (1), TW tag bits LSB first, BITSA+1 data bits LSB first,
// optional even-parity bit, then GAP idle cycles with the line released.
// Optional feature macro: BITSA_SERIAL_TX_PARITY_EN (even parity over tag+data).
// Ports:
//   clk       - sole clock, rising edge
//   rst       - asynchronous active-high reset
//   in_valid  - word offered
//   in_ready  - block idle and able to accept a word
//   in_data   - word to send [BITSA:0]
//   in_tag    - tag sent ahead of the word (BITSB_t)
//   tx_out    - serial line value (0 whenever tx_oe is 0)
//   tx_oe     - line drive enable
//   tx_frame  - high only during the start-bit cycle
//   busy      - high in every state except IDLE
module bitsa_serial_tx
    import bitsa_tx_pkg::*;
#(
    parameter int  BITSA   = 7,
    parameter type BITSB_t = bitsa_tag_t,
    parameter int  GAP     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [BITSA:0] in_data,
    input  BITSB_t       in_tag,
    output logic         tx_out,
    output logic         tx_oe,
    output logic         tx_frame,
    output logic         busy
);

    localparam int W     = BITSA + 1;
    localparam int TW    = $bits(BITSB_t);
    localparam int SW    = TW + W;
    localparam int MAX_A = (W > TW) ? W : TW;
    localparam int MAX_C = (MAX_A > GAP) ? MAX_A : GAP;
    localparam int CNT_W = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] TAG_LAST  = CNT_W'(TW - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    // With no gap configured the frame returns straight to IDLE.
    localparam bitsa_state_e AFTER_DATA = (GAP > 0) ? ST_GAP : ST_IDLE;

    bitsa_state_e     state_q, state_d;
    logic [SW-1:0]    sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]    tag_bits;

    assign tag_bits = in_tag;

`ifdef BITSA_SERIAL_TX_PARITY_EN
    // Parity is captured at accept time because the shifter empties itself.
    logic par_q, par_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
`ifdef BITSA_SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
`ifdef BITSA_SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
`ifdef BITSA_SERIAL_TX_PARITY_EN
        par_d    = par_q;
`endif
        tx_out   = 1'b0;
        tx_oe    = 1'b0;
        tx_frame = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_START;
                    // Tag sits in the low bits so it leaves the shifter first.
                    sh_d    = {in_data, tag_bits};
`ifdef BITSA_SERIAL_TX_PARITY_EN
                    par_d   = ^{in_data, tag_bits};
`endif
                end
            end
            ST_START: begin
                tx_out   = 1'b1;
                tx_oe    = 1'b1;
                tx_frame = 1'b1;
                state_d  = ST_TAG;
            end
            ST_TAG: begin
                tx_oe  = 1'b1;
                tx_out = sh_q[0];
                sh_d   = sh_q >> 1;
                if (cnt_q == TAG_LAST) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_oe  = 1'b1;
                tx_out = sh_q[0];
                sh_d   = sh_q >> 1;
                if (cnt_q == DATA_LAST) begin
`ifdef BITSA_SERIAL_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = AFTER_DATA;
`endif
                end
            end
`ifdef BITSA_SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                tx_oe   = 1'b1;
                tx_out  = par_q;
                state_d = AFTER_DATA;
            end
`endif
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Counter measures time spent in the current state only.
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Gated with rst so the block never advertises readiness while held in reset.
    assign in_ready = (state_q == ST_IDLE) && !rst;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bitsa_serial_tx.sv
// tb/tb_bitsa_serial_tx.sv - scoreboard bench for bitsa_serial_tx
module tb_bitsa_serial_tx;
    import bitsa_tx_pkg::*;

    localparam int TW  = 3;
    localparam int W   = 8;
    localparam int GAP = 1;
`ifdef BITSA_SERIAL_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int PERIOD = 1 + TW + W + PB + GAP + 1;
    localparam int NL     = 1 + TW + W + PB;
    localparam int W0     = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    bitsa_tag_t in_tag = '0;
    logic       tx_out, tx_oe, tx_frame, busy;

    logic       in_valid0 = 1'b0;
    logic       in_ready0;
    logic [3:0] in_data0 = '0;
    bitsa_tag_t in_tag0 = '0;
    logic       tx_out0, tx_oe0, tx_frame0, busy0;

    bitsa_serial_tx #(.BITSA(7), .BITSB_t(bitsa_tag_t), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_tag(in_tag), .tx_out(tx_out), .tx_oe(tx_oe),
        .tx_frame(tx_frame), .busy(busy)
    );

    bitsa_serial_tx #(.BITSA(3), .BITSB_t(bitsa_tag_t), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data0), .in_tag(in_tag0), .tx_out(tx_out0), .tx_oe(tx_oe0),
        .tx_frame(tx_frame0), .busy(busy0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [1:0] exp_q[$];   // {tx_out, tx_frame} per driven cycle
    bit cont_mode = 0;
    bit prev_cont = 0;
    logic prev_oe = 1'b0;
    int low_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference frame: start bit, tag LSB first, data LSB first, even parity.
    task automatic push_model(input logic [7:0] d, input logic [2:0] t);
        exp_q.push_back(2'b11);
        for (int i = 0; i < TW; i++) exp_q.push_back({t[i], 1'b0});
        for (int i = 0; i < W; i++) exp_q.push_back({d[i], 1'b0});
        if (PB == 1) exp_q.push_back({^{d, t}, 1'b0});
    endtask

    // Literal expected line, first bit in v[12].
    task automatic push_lit(input logic [12:0] v);
        exp_q.push_back({v[12], 1'b1});
        for (int i = 1; i < NL; i++) exp_q.push_back({v[12-i], 1'b0});
    endtask

    // Monitor: every driven cycle consumes one expected bit.
    always @(negedge clk) begin
        logic [1:0] e;
        if (tx_oe) begin
            if (!prev_oe) begin
                if (cont_mode && prev_cont) check("oe_low_between_frames", low_run, GAP + 1);
                prev_cont = cont_mode;
            end
            check("sb_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tx_bit", {tx_out, tx_frame}, e);
            end
            low_run = 0;
        end else begin
            if (tx_out !== 1'b0 || tx_frame !== 1'b0) check("idle_line", {tx_out, tx_frame}, 0);
            low_run++;
        end
        prev_oe = tx_oe;
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [7:0] d, input logic [2:0] t, input bit lit, input logic [12:0] v);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        @(negedge clk);
        while (!in_ready && n < 64) begin
            n++;
            @(negedge clk);
        end
        check("accept_ready", in_ready, 1);
        if (lit) push_lit(v);
        else push_model(d, t);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_tag   = 3'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 64) begin
            n++;
            @(negedge clk);
        end
        check("return_idle", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int last_acc;
        int accs;
        int n;

        // Reset held for three cycles.
        repeat (3) begin
            @(negedge clk);
            check("rst_tx_oe", tx_oe, 0);
            check("rst_busy", busy, 0);
            check("rst_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);
        @(posedge clk);
        #1;

        // Directed frames with literal line patterns.
        send(8'hA5, 3'b101, 1, 13'b1_101_10100101_0);
        wait_idle();
        send(8'hA4, 3'b101, 1, 13'b1_101_00100101_1);
        wait_idle();

        // Random words with random idle spacing; inputs scrambled while busy.
        for (int k = 0; k < 20; k++) begin
            send(8'($urandom), 3'($urandom), 0, '0);
            n = $urandom_range(0, 3);
            repeat (n) @(posedge clk);
            #1;
        end
        wait_idle();

        // Continuous in_valid: accept spacing and line release between frames.
        cont_mode = 1;
        in_valid  = 1'b1;
        accs = 0;
        n = 0;
        last_acc = 0;
        while (accs < 5 && n < 200) begin
            @(negedge clk);
            if (in_ready) begin
                push_model(in_data, in_tag);
                if (accs > 0) check("accept_spacing", cyc - last_acc, PERIOD);
                last_acc = cyc;
                accs++;
            end
            @(posedge clk);
            #1;
            in_data = 8'($urandom);
            in_tag  = 3'($urandom);
            n++;
        end
        check("cont_accepts", accs, 5);
        in_valid = 1'b0;
        wait_idle();
        cont_mode = 0;

        // Reset pulse during data bit 3.
        send(8'($urandom), 3'($urandom), 0, '0);
        repeat (7) @(posedge clk);
        #1;
        check("pre_rst_driving", tx_oe, 1);
        #1 rst = 1'b1;
        #1;
        check("midrst_tx_oe", tx_oe, 0);
        check("midrst_tx_out", tx_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        send(8'($urandom), 3'($urandom), 0, '0);
        wait_idle();

        // GAP=0 instance: ready in the cycle right after the last driven bit.
        in_valid0 = 1'b1;
        in_data0  = 4'($urandom);
        in_tag0   = 3'($urandom);
        @(negedge clk);
        check("g0_ready_initial", in_ready0, 1);
        @(posedge clk);
        #1 in_valid0 = 1'b0;
        for (int k = 0; k < 1 + TW + W0 + PB; k++) begin
            @(negedge clk);
            if (in_ready0 !== 1'b0 || tx_oe0 !== 1'b1) check("g0_in_frame", {in_ready0, tx_oe0}, 2'b01);
        end
        @(negedge clk);
        check("g0_ready_after_last", in_ready0, 1);
        check("g0_oe_released", tx_oe0, 0);

        @(posedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/bitsa_serial_tx.md
BITSA_SERIAL_TX -- requirements
Module: bitsa_serial_tx

Interface
REQ-001 The block SHALL have parameter BITSA, default 7, data word MSB index (word width BITSA+1).
REQ-002 The block SHALL have type parameter BITSB_t, default logic [2:0], frame tag type (tag width TW = $bits(BITSB_t)).
REQ-003 The block SHALL have parameter GAP, default 1, idle cycles after each frame (0 allowed).
REQ-004 The block SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-006 The block SHALL have port in_valid, input, 1, word offered.
REQ-007 The block SHALL have port in_ready, output, 1, block can accept a word.
REQ-008 The block SHALL have port in_data, input, [BITSA:0], word to send.
REQ-009 The block SHALL have port in_tag, input, BITSB_t, tag sent ahead of the word.
REQ-010 The block SHALL have port tx_out, output, 1, serial line value.
REQ-011 The block SHALL have port tx_oe, output, 1, line drive enable for the shared inout bus.
REQ-012 The block SHALL have port tx_frame, output, 1, high only during the start-bit cycle.
REQ-013 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, START, TAG, DATA, PARITY (when configured) and GAP.
REQ-015 in_ready SHALL equal (state==IDLE) and SHALL be 0 while rst is high.
REQ-016 in_valid && in_ready at edge N SHALL register in_data and in_tag and SHALL enter START, which drives the start bit in cycle N+1.
REQ-017 START SHALL drive tx_out=1 and tx_frame=1 for exactly one cycle.
REQ-018 TAG SHALL shift TW tag bits out LSB first, one per cycle.
REQ-019 DATA SHALL shift BITSA+1 data bits out LSB first, one per cycle.
REQ-020 After DATA (or PARITY), the FSM SHALL spend GAP cycles in GAP, then enter IDLE; with GAP=0 it SHALL go directly to IDLE.
REQ-021 tx_oe SHALL be 1 in START, TAG, DATA and PARITY, and 0 in IDLE and GAP.
REQ-022 tx_out SHALL be 0 whenever tx_oe is 0.
REQ-023 in_valid, in_data and in_tag SHALL be ignored while busy; changes to them after acceptance SHALL NOT affect the frame in flight.
REQ-024 The bit counter width SHALL be $clog2(max(BITSA+1, TW, GAP)+1), and the counter SHALL reload to 0 on every state change.
REQ-025 The frame period SHALL be 1 + TW + (BITSA+1) [+1 with parity] + GAP + 1 idle cycles, so back-to-back words with BITSA=7, TW=3, GAP=1 are accepted every 14 cycles.

Reset
REQ-026 Assertion of rst SHALL immediately force state to IDLE and set tx_oe=0, tx_out=0, tx_frame=0, busy=0 and in_ready=0, and SHALL clear the shift register and counter.
REQ-027 Reset mid-frame SHALL abandon the frame without completion, and the first accept SHALL be possible at the first clk edge after rst deasserts.

Configuration
REQ-028 With BITSA_SERIAL_TX_PARITY_EN defined, the PARITY state SHALL drive one bit after DATA that makes even the count of ones over tag bits, data bits and the parity bit.
REQ-029 Without BITSA_SERIAL_TX_PARITY_EN, the PARITY state and its logic SHALL be absent and DATA SHALL proceed directly to GAP or IDLE.

Structure
REQ-030 Package bitsa_tx_pkg SHALL hold the state enum and the default tag typedef bitsa_tag_t (logic [2:0]).
REQ-031 The block SHALL be a single module with no sub-module, because the shift register and counter are too small to warrant one.

Verification
REQ-032 rst held for 3 cycles and then released SHALL give tx_oe=0, busy=0, in_ready=0 during reset and in_ready=1 in the first cycle after release.
REQ-033 With BITSA=7, no parity, in_data=8'hA5 and in_tag=3'b101, tx_out over 12 cycles SHALL be 1 | 1,0,1 | 1,0,1,0,0,1,0,1, with tx_frame high only in the first of those cycles.
REQ-034 The same stimulus with BITSA_SERIAL_TX_PARITY_EN defined SHALL produce a 13th bit of 0, and in_data=8'hA4 with the same tag SHALL produce a 13th bit of 1.
REQ-035 in_valid held high continuously with GAP=1 SHALL give accepts exactly 14 cycles apart and SHALL keep tx_oe low for 2 cycles between frames.
REQ-036 rst pulsed during data bit 3 SHALL drop tx_oe to 0 in the same cycle, and a new word SHALL then start with a clean start bit.
REQ-037 With GAP=0, in_ready SHALL be high in the cycle immediately after the last data bit.
